// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, address
// constants and the bit positions of the error-cause vector.
package data_mem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int          WORD_BYTES    = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_BELOW    = 1;
  localparam int ERR_RANGE    = 2;
  localparam int ERR_CONFLICT = 3;
  localparam int ERR_W        = 4;

  typedef struct packed {
    logic             isLoad;
    logic [ERR_W-1:0] err;
  } reqInfo_t;

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous RAM backing the responder; contents survive reset.
module data_ram_sp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: one word load/store at a time with WAIT_STATES of
// added latency, Stall while busy, one-cycle Ready/AddrError response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Ready,
  output logic                  AddrError
);

  localparam int AW = $clog2(MEMORY_DEPTH);

  logic [1:0]            state;
  logic [3:0]            cnt;
  reqInfo_t              lat;
  logic [AW-1:0]         latIdx;
  logic [DATA_WIDTH-1:0] latData;
  logic [DATA_WIDTH-1:0] dataHold;
  logic [DATA_WIDTH-1:0] ramRdata;
  logic [DATA_WIDTH-1:0] respData;
  logic [AW-1:0]         ramAddr;
  logic                  ramWe;
  logic                  req;
  logic [29:0]           wordOff;
  logic [ERR_W-1:0]      cause;

  assign req     = MemRead | MemWrite;
  assign wordOff = Address[31:2] - BASE_ADDR[31:2];

  always_comb begin
    cause               = '0;
    cause[ERR_MISALIGN] = |Address[1:0];
    cause[ERR_BELOW]    = Address < BASE_ADDR;
    cause[ERR_RANGE]    = |wordOff[29:AW];
    cause[ERR_CONFLICT] = MemRead & MemWrite;
  end

  // The RAM reads synchronously, so in IDLE it is pointed at the incoming
  // address; that way a zero-wait-state load has its data ready in RESP.
  assign ramAddr  = (state == ST_IDLE) ? wordOff[AW-1:0] : latIdx;
  assign ramWe    = (state == ST_RESP) && !lat.isLoad && (lat.err == '0);
  assign respData = (lat.err != '0) ? '0 : (lat.isLoad ? ramRdata : dataHold);

  assign ReadData  = (state == ST_RESP) ? respData : dataHold;
  assign Ready     = (state == ST_RESP);
  assign AddrError = (state == ST_RESP) && (lat.err != '0);
  assign Stall     = reset && (((state == ST_IDLE) && req) || (state == ST_WAIT));

  data_ram_sp #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEMORY_DEPTH), .AW(AW)) uRam (
    .clk   (clk),
    .we    (ramWe),
    .addr  (ramAddr),
    .wdata (latData),
    .rdata (ramRdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat      <= '0;
      latIdx   <= '0;
      latData  <= '0;
      dataHold <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          lat.isLoad <= MemRead;
          lat.err    <= cause;
          latIdx     <= wordOff[AW-1:0];
          latData    <= WriteData;
          cnt        <= 4'(WAIT_STATES);
          state      <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          dataHold <= respData;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: dut0 runs with two wait states, dut1 with none.
module tb_data_mem_responder;

  localparam int          DW    = 32;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rstN, memRead, memWrite, stall, ready, addrError;
  logic [1:0][31:0]   address, writeData, readData;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] lastData [2];

  data_mem_responder #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(rstN[0]), .MemRead(memRead[0]), .MemWrite(memWrite[0]),
    .Address(address[0]), .WriteData(writeData[0]), .ReadData(readData[0]),
    .Stall(stall[0]), .Ready(ready[0]), .AddrError(addrError[0])
  );

  data_mem_responder #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(rstN[1]), .MemRead(memRead[1]), .MemWrite(memWrite[1]),
    .Address(address[1]), .WriteData(writeData[1]), .ReadData(readData[1]),
    .Stall(stall[1]), .Ready(ready[1]), .AddrError(addrError[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit modelErr(input logic [31:0] a, input bit rd, input bit wr);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (a < BASE) || (off >= 32'(4 * DEPTH)) || (rd && wr);
  endfunction

  // One request through the core handshake: hold until Stall drops, pop the
  // expected response when Ready appears. toggle perturbs Address mid-flight.
  task automatic doReq(input int d, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] wd, input bit toggle);
    exp_t        e, o;
    int          ws;
    int          cyc;
    int          stalls;
    bit          got;
    logic [31:0] off;
    logic [7:0]  idx;
    ws     = (d == 0) ? 2 : 0;
    cyc    = 0;
    stalls = 0;
    got    = 0;
    off    = (a - BASE) >> 2;
    idx    = off[7:0];
    e.d    = d;
    e.err  = modelErr(a, rd, wr);
    if (e.err)   e.data = '0;
    else if (rd) e.data = mdl[d][idx];
    else         e.data = lastData[d];
    if (!e.err && wr) mdl[d][idx] = wd;
    lastData[d] = e.data;
    sb.push_back(e);

    @(negedge clk);
    memRead[d] = rd; memWrite[d] = wr; address[d] = a; writeData[d] = wd;
    #1;
    while (!got && cyc < 40) begin
      if (stall[d]) stalls++;
      if (ready[d]) begin
        got = 1;
        o = sb.pop_front();
        chk("latency", 32'(cyc), 32'(ws + 1));
        chk("dutId", 32'(d), 32'(o.d));
        chk("readData", readData[d], o.data);
        chk("addrError", 32'(addrError[d]), 32'(o.err));
      end else begin
        if (toggle && cyc == 1) address[d] = a ^ 32'h4;
        @(negedge clk); #1;
        cyc++;
      end
    end
    memRead[d] = 1'b0; memWrite[d] = 1'b0;
    if (!got) chk("timeout", 32'd0, 32'd1);
    chk("stallCycles", 32'(stalls), 32'(ws + 1));
  endtask

  initial begin
    int readyCnt, stallCnt;
    rstN = 2'b00; memRead = '0; memWrite = '0; address = '0; writeData = '0;
    lastData[0] = '0; lastData[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstStall0", 32'(stall[0]), 32'd0);
    chk("rstReady0", 32'(ready[0]), 32'd0);
    chk("rstErr0", 32'(addrError[0]), 32'd0);
    chk("rstData0", readData[0], 32'd0);
    chk("rstData1", readData[1], 32'd0);
    @(negedge clk);
    rstN = 2'b11;

    // two-wait-state instance: basic store/load, errors, aliasing, conflicts
    doReq(0, 0, 1, BASE,             32'hA5A5_0000, 0);
    doReq(0, 0, 1, 32'h1001_03FC,    32'h0000_00FF, 0);
    doReq(0, 0, 1, 32'h1001_0004,    32'hDEAD_BEEF, 0);
    doReq(0, 1, 0, 32'h1001_0004,    32'h0,         0);
    doReq(0, 1, 0, 32'h1001_0002,    32'h0,         0);
    doReq(0, 1, 0, 32'h1000_FFFC,    32'h0,         0);
    doReq(0, 0, 1, 32'h1001_0002,    32'h1111_1111, 0);
    doReq(0, 0, 1, 32'h1000_FFFC,    32'h2222_2222, 0);
    doReq(0, 1, 0, BASE,             32'h0,         0);
    doReq(0, 1, 0, 32'h1001_03FC,    32'h0,         0);
    doReq(0, 0, 1, BASE + 32'(4 * DEPTH), 32'h3333_3333, 0);
    doReq(0, 1, 0, BASE,             32'h0,         0);
    doReq(0, 1, 1, 32'h1001_0004,    32'h4444_4444, 0);
    doReq(0, 1, 0, 32'h1001_0004,    32'h0,         0);
    doReq(0, 1, 0, 32'h1001_0004,    32'h0,         1);
    doReq(0, 0, 1, BASE,             32'h5555_5555, 1);
    doReq(0, 1, 0, BASE,             32'h0,         0);
    doReq(0, 1, 0, 32'h1001_0004,    32'h0,         0);

    // reset asserted while a store sits in WAIT: aborted, no response
    @(negedge clk);
    memWrite[0] = 1'b1; address[0] = 32'h1001_0004; writeData[0] = 32'h1234_5678;
    @(negedge clk);
    rstN[0] = 1'b0;
    #1;
    chk("abortStall", 32'(stall[0]), 32'd0);
    chk("abortReady", 32'(ready[0]), 32'd0);
    readyCnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (ready[0]) readyCnt++;
    end
    chk("abortNoReady", 32'(readyCnt), 32'd0);
    chk("abortData", readData[0], 32'd0);
    memWrite[0] = 1'b0;
    rstN[0] = 1'b1;
    lastData[0] = '0;
    doReq(0, 1, 0, 32'h1001_0004, 32'h0, 0);

    // zero-wait-state instance
    doReq(1, 0, 1, BASE,          32'h0BAD_F00D, 0);
    doReq(1, 1, 0, BASE,          32'h0,         0);
    doReq(1, 1, 0, 32'h1001_0006, 32'h0,         0);
    doReq(1, 1, 0, BASE,          32'h0,         0);

    // load held continuously: accept, RESP, accept, ... one gap cycle each
    @(negedge clk);
    memRead[1] = 1'b1; address[1] = BASE;
    readyCnt = 0; stallCnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ready[1]) readyCnt++;
      if (stall[1]) stallCnt++;
      @(negedge clk);
    end
    memRead[1] = 1'b0;
    chk("b2bReady", 32'(readyCnt), 32'd3);
    chk("b2bStall", 32'(stallCnt), 32'd3);
    #1;
    chk("b2bData", readData[1], 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
